ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage feeding the control decoder and the datapath of the single-issue RV32 NPC core.
//  Owns the architectural PC. Issues one word read per instruction on a valid/ready memory port.
//  Holds the fetched instruction stable while it is executed, then selects the next PC (snpc or ALU target) from PCSrc.
// PARAMETERS
//  RESET_PC    32'h8000_0000  PC loaded on reset; first fetch address
//  ADDR_W      32             address/PC width
//  TIMEOUT_W   8              width of the response-wait watchdog counter; 0 disables the watchdog
// PORTS
//  clk             in   1       core clock; all state on posedge
//  rst             in   1       asynchronous, active-high reset
//  mem_req_valid   out  1       read request valid
//  mem_req_ready   in   1       memory accepts the request
//  mem_req_addr    out  ADDR_W  word address; always equals pc, bits[1:0]=0
//  mem_resp_valid  in   1       read data valid
//  mem_resp_data   in   32      instruction word
//  mem_resp_ready  out  1       ifu accepts the response
//  inst            out  32      instruction to control/imm-gen; held during EXEC
//  pc              out  ADDR_W  address of inst
//  snpc            out  ADDR_W  pc+4, wrap modulo 2^ADDR_W; used by the jal/jalr writeback
//  inst_valid      out  1       inst/pc are valid for execution this cycle
//  exec_done       in   1       datapath retires inst this cycle (single-cycle core: tie to 1)
//  pc_src          in   1       0 = next PC is snpc; 1 = next PC is alu_result
//  alu_result      in   ADDR_W  jump target from the ALU
//  fetch_err       out  1       sticky: misaligned target or watchdog timeout; cleared only by rst
// BEHAVIOUR
//  FSM states: REQ, WAIT, EXEC, HALT. Reset state is REQ.
//  Reset values: pc=RESET_PC, inst=32'h0000_0013 (nop), inst_valid=0, fetch_err=0, watchdog=0.
//  REQ:
//    - mem_req_valid=1.
//    - On mem_req_ready: go to WAIT.
//    - mem_req_addr/pc are stable while the request is unaccepted.
//  WAIT:
//    - mem_resp_ready=1.
//    - On mem_resp_valid: latch inst<=mem_resp_data, go to EXEC.
//    - The watchdog increments each WAIT cycle. When it reaches all-ones: fetch_err<=1, go to HALT.
//  EXEC:
//    - inst_valid=1. inst, pc and snpc are unchanged.
//    - On exec_done: compute npc = pc_src ? {alu_result[ADDR_W-1:1],1'b0} : snpc (bit0 cleared for jalr).
//      - npc[1]=1: fetch_err<=1, go to HALT; pc is not updated.
//      - Otherwise pc<=npc and go to REQ.
//  HALT:
//    - Terminal state. All handshake outputs are 0 and inst_valid=0. Only rst exits.
//  Responses are ignored (mem_resp_ready=0) outside WAIT. A stray mem_resp_valid in REQ/EXEC is dropped without error.
//  Minimum latency per instruction: REQ(1) + WAIT(1) + EXEC(1) = 3 cycles when ready/valid are asserted immediately.
//  A request and its response in the same cycle is not accepted: the response must arrive at or after the cycle following request acceptance.
//  rst asserted mid-WAIT abandons the transaction. After reset the ifu re-fetches RESET_PC.
//  A late response from the abandoned request arrives in REQ and is dropped.
//  snpc wrap: pc=32'hFFFF_FFFC gives snpc=32'h0000_0000, with no error.
// STRUCTURE
//  Shared package/defines.vh gets:
//    - IFU state encodings (IFU_REQ, IFU_WAIT, IFU_EXEC, IFU_HALT)
//    - NOP_INST=32'h0000_0013
//    - the PC_FROM_SNPC/PC_FROM_ALU values, which pc_src must match
//  One sub-module: ifu_pc_reg (PC register + npc mux + alignment check); the FSM and watchdog stay in ifu_fetch.
// TESTING
//  1 Reset, memory always ready, resp one cycle later -> addrs 8000_0000, 8000_0004, 8000_0008; inst_valid pulses every 3rd cycle.
//  2 pc_src=1, alu_result=8000_0101 in EXEC -> next mem_req_addr=8000_0100, fetch_err=0.
//  3 pc_src=1, alu_result=8000_0102 -> fetch_err=1, state HALT, no further mem_req_valid.
//  4 mem_req_ready held 0 for 5 cycles -> addr stable and valid held; resp 3 cycles late -> inst latched correctly.
//  5 Assert rst in WAIT, inject stale resp after release -> dropped; first fetch is 8000_0000 with fresh data.
//  6 TIMEOUT_W=4, resp never returns -> fetch_err=1 after 15 WAIT cycles; pc=FFFF_FFFC sequential -> next addr 0000_0000.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, the reset
// instruction and the pc_src select values.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_EXEC = 2'd2,
    IFU_HALT = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic PC_FROM_SNPC = 1'b0;
  localparam logic PC_FROM_ALU  = 1'b1;

endpackage

// File: rtl/ifu_pc_reg.sv
// Architectural PC register with the next-PC mux and the word-alignment check
// on the selected target.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] snpc,
  output logic [ADDR_W-1:0] npc,
  output logic              npc_misaligned
);

  // Wraps naturally modulo 2^ADDR_W.
  assign snpc = pc + ADDR_W'(4);

  // Bit 0 of an ALU target is dropped so jalr lands on an even address.
  always_comb begin
    npc = snpc;
    if (pc_src == PC_FROM_ALU) begin
      npc = {alu_result[ADDR_W-1:1], 1'b0};
    end
  end

  assign npc_misaligned = npc[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= npc;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: request/response FSM, response watchdog, held
// instruction register and sticky error flag around the PC register.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h8000_0000,
  parameter int                TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              mem_resp_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] snpc,
  output logic              inst_valid,
  input  logic              exec_done,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] alu_result,
  output logic              fetch_err,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // The ifu raises mem_req_valid only in REQ and mem_resp_ready only in WAIT,
  // so a response can never complete in the same cycle as its request.

  ifu_state_e        state_q, state_d;
  logic              pc_load;
  logic              inst_load;
  logic              err_set;
  logic              wd_expire;
  logic [ADDR_W-1:0] npc;
  logic              npc_misaligned;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (pc_load),
    .pc_src         (pc_src),
    .alu_result     (alu_result),
    .pc             (pc),
    .snpc           (snpc),
    .npc            (npc),
    .npc_misaligned (npc_misaligned)
  );

  assign mem_req_addr = pc;
  assign state_dbg    = state_q;

  // Counter restarts every time WAIT is entered; expiry fires on the WAIT
  // cycle that would bring it to all-ones, unless a response arrives then.
  generate
    if (TIMEOUT_W > 0) begin : g_wd
      localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);
      logic [TIMEOUT_W-1:0] wd_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wd_q <= '0;
        end else if (state_q == IFU_WAIT) begin
          wd_q <= wd_q + TIMEOUT_W'(1);
        end else begin
          wd_q <= '0;
        end
      end

      assign wd_expire = (state_q == IFU_WAIT) && !mem_resp_valid && (wd_q == WD_LAST);
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFU_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_load        = 1'b0;
    inst_load      = 1'b0;
    err_set        = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    inst_valid     = 1'b0;
    case (state_q)
      IFU_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          inst_load = 1'b1;
          state_d   = IFU_EXEC;
        end else if (wd_expire) begin
          err_set = 1'b1;
          state_d = IFU_HALT;
        end
      end
      IFU_EXEC: begin
        inst_valid = 1'b1;
        if (exec_done) begin
          if (npc_misaligned) begin
            err_set = 1'b1;
            state_d = IFU_HALT;
          end else begin
            pc_load = 1'b1;
            state_d = IFU_REQ;
          end
        end
      end
      IFU_HALT: begin
        state_d = IFU_HALT;
      end
      default: begin
        state_d = IFU_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst <= NOP_INST;
    end else if (inst_load) begin
      inst <= mem_resp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else if (err_set) begin
      fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a responding memory model, an instruction
// scoreboard, and a second instance with a short watchdog.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic [31:0] inst, pc, snpc, alu_result;
  logic        inst_valid, exec_done, pc_src, fetch_err;
  logic [1:0]  state_dbg;

  logic        rst_b;
  logic        b_req_valid, b_resp_ready, b_inst_valid, b_fetch_err;
  logic [31:0] b_req_addr, b_inst, b_pc, b_snpc;
  logic [1:0]  b_state;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int exec_cyc_prev = 0;
  int exec_cyc_last = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cycle++;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_ready (mem_resp_ready),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .inst_valid     (inst_valid),
    .exec_done      (exec_done),
    .pc_src         (pc_src),
    .alu_result     (alu_result),
    .fetch_err      (fetch_err),
    .state_dbg      (state_dbg)
  );

  ifu_fetch #(.TIMEOUT_W(4)) dut_b (
    .clk            (clk),
    .rst            (rst_b),
    .mem_req_valid  (b_req_valid),
    .mem_req_ready  (1'b1),
    .mem_req_addr   (b_req_addr),
    .mem_resp_valid (1'b0),
    .mem_resp_data  (32'h0),
    .mem_resp_ready (b_resp_ready),
    .inst           (b_inst),
    .pc             (b_pc),
    .snpc           (b_snpc),
    .inst_valid     (b_inst_valid),
    .exec_done      (1'b0),
    .pc_src         (1'b0),
    .alu_result     (32'h0),
    .fetch_err      (b_fetch_err),
    .state_dbg      (b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!mem_req_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("req_wait_bound", {31'b0, mem_req_valid}, 32'd1);
  endtask

  // One full REQ -> WAIT -> EXEC pass with optional handshake stalls.
  task automatic fetch_one(input logic [31:0] addr, input int req_dly, input int resp_dly,
                           input logic [31:0] data, input logic src, input logic [31:0] alu);
    logic [31:0] nxt;
    nxt = addr + 32'd4;
    wait_req(20);
    check("req_addr", mem_req_addr, addr);
    check("req_inst_valid_low", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i < req_dly; i++) begin
      mem_req_ready = 1'b0;
      @(negedge clk);
      check("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
      check("req_hold_addr", mem_req_addr, addr);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("wait_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
    check("wait_req_valid_low", {31'b0, mem_req_valid}, 32'd0);
    for (int i = 0; i < resp_dly; i++) begin
      @(negedge clk);
      check("wait_hold_ready", {31'b0, mem_resp_ready}, 32'd1);
      check("wait_inst_valid_low", {31'b0, inst_valid}, 32'd0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    exp_q.push_back(data);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'hDEAD_BEEF;
    check("exec_inst_valid", {31'b0, inst_valid}, 32'd1);
    if (inst_valid) begin
      check("exec_inst", inst, exp_q.pop_front());
      exec_cyc_prev = exec_cyc_last;
      exec_cyc_last = cycle;
    end
    check("exec_pc", pc, addr);
    check("exec_snpc", snpc, nxt);
    exec_done  = 1'b1;
    pc_src     = src;
    alu_result = alu;
    @(negedge clk);
    exec_done  = 1'b0;
    pc_src     = PC_FROM_SNPC;
    alu_result = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    rst            = 1'b1;
    rst_b          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    exec_done      = 1'b0;
    pc_src         = PC_FROM_SNPC;
    alu_result     = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, NOP_INST);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, 32'(IFU_REQ));
    check("rst_b_pc", b_pc, 32'h8000_0000);
    rst = 1'b0;

    // Sequential fetch at full rate
    fetch_one(32'h8000_0000, 0, 0, 32'h0000_0093, PC_FROM_SNPC, 32'h0);
    fetch_one(32'h8000_0004, 0, 0, 32'h0010_8113, PC_FROM_SNPC, 32'h0);
    check("ivalid_period_a", exec_cyc_last - exec_cyc_prev, 32'd3);
    // Jump with bit0 set on the target
    fetch_one(32'h8000_0008, 0, 0, 32'h1000_006F, PC_FROM_ALU, 32'h8000_0101);
    check("ivalid_period_b", exec_cyc_last - exec_cyc_prev, 32'd3);
    check("jmp_no_err", {31'b0, fetch_err}, 32'd0);
    // Stalled request and late response
    fetch_one(32'h8000_0100, 5, 3, 32'hABCD_1237, PC_FROM_SNPC, 32'h0);
    fetch_one(32'h8000_0104, 0, 0, 32'h0000_0067, PC_FROM_ALU, 32'hFFFF_FFFC);
    // PC at the top of the address space wraps to zero
    fetch_one(32'hFFFF_FFFC, 0, 0, 32'h0040_0513, PC_FROM_SNPC, 32'h0);
    check("wrap_no_err", {31'b0, fetch_err}, 32'd0);
    // Misaligned jump target halts
    fetch_one(32'h0000_0000, 0, 0, 32'h0020_00E7, PC_FROM_ALU, 32'h8000_0102);
    check("halt_fetch_err", {31'b0, fetch_err}, 32'd1);
    check("halt_state", {30'b0, state_dbg}, 32'(IFU_HALT));
    check("halt_pc_kept", pc, 32'h0000_0000);
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("halt_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
      check("halt_inst_valid", {31'b0, inst_valid}, 32'd0);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;

    // Reset out of HALT, then reset again in the middle of WAIT
    rst = 1'b1;
    #1;
    check("rst2_state", {30'b0, state_dbg}, 32'(IFU_REQ));
    check("rst2_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst2_inst", inst, NOP_INST);
    @(negedge clk);
    rst = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("mid_wait_state", {30'b0, state_dbg}, 32'(IFU_WAIT));
    rst = 1'b1;
    #1;
    check("mid_rst_state", {30'b0, state_dbg}, 32'(IFU_REQ));
    check("mid_rst_pc", pc, 32'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    // Stale response from the abandoned request
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_BAD0;
    check("stale_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("stale_state", {30'b0, state_dbg}, 32'(IFU_REQ));
    check("stale_no_err", {31'b0, fetch_err}, 32'd0);
    check("stale_inst", inst, NOP_INST);
    fetch_one(32'h8000_0000, 0, 1, 32'h0050_0593, PC_FROM_SNPC, 32'h0);
    fetch_one(32'h8000_0004, 0, 0, 32'h0060_0613, PC_FROM_SNPC, 32'h0);

    // Watchdog on the 4-bit instance: memory never answers
    rst_b = 1'b0;
    k = 0;
    while (!b_fetch_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    // One cycle in REQ, then fifteen WAIT cycles
    check("wd_cycles", k, 32'd16);
    check("wd_state", {30'b0, b_state}, 32'(IFU_HALT));
    check("wd_req_valid", {31'b0, b_req_valid}, 32'd0);
    check("wd_resp_ready", {31'b0, b_resp_ready}, 32'd0);
    check("wd_inst", b_inst, NOP_INST);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
